// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, control encodings, ID/EX record
// and the immediate sign-extension helper.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_control_e;

  // IMM_NONE covers R-type and bubbles, whose immediate is forced to zero
  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_NONE = 3'b100
  } imm_src_e;

  typedef struct packed {
    logic         reg_write;
    logic         mem_write;
    logic         jump;
    logic         branch;
    logic         alu_src;
    result_src_e  result_src;
    alu_control_e alu_control;
    logic [31:0]  rd1;
    logic [31:0]  rd2;
    logic [31:0]  imm_ext;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
  } id_ex_t;

  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input imm_src_e  src);
    logic [31:0] imm;
    imm = '0;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write bypass,
// one synchronous write port, synchronous active-high reset clearing all entries.
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  // Next register contents: x0 is never written so it stays zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  // Reset wins over any write landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // Read ports return the in-flight writeback value so ID sees it this cycle
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != '0) rd1 = (wr_en && (wa == a1)) ? wd : regs_q[a1];
    if (a2 != '0) rd2 = (wr_en && (wa == a2)) ? wd : regs_q[a2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage with ID/EX pipeline register.
// Build option: define DECODE_ILLEGAL_FLAG_EN to add the registered IllegalE
// output flagging nonzero instructions with an unrecognised opcode.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
`ifdef DECODE_ILLEGAL_FLAG_EN
  output logic            IllegalE,
`endif
  output logic [4:0]      Rs2E
);
  import riscv_pkg::*;

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         reg_write, mem_write, jump, branch, alu_src, listed;
  result_src_e  result_src;
  imm_src_e     imm_src;
  logic [1:0]   alu_op;
  alu_control_e alu_control;
  logic [XLEN-1:0] rd1, rd2;
  id_ex_t       id_ex_d, id_ex_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_register_file (
    .clk (clk),
    .rst (rst),
    .a1  (Rs1D),
    .a2  (Rs2D),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Main decoder; alu_op 00 = add, 01 = sub, 10 = use funct3/funct7
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    result_src = RES_ALU;
    imm_src    = IMM_NONE;
    alu_op     = 2'b00;
    listed     = 1'b1;
    case (opcode)
      OP_LOAD:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; imm_src = IMM_I; end
      OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
      OP_RTYPE:  begin reg_write = 1'b1; alu_op = 2'b10; end
      OP_IALU:   begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_I; alu_op = 2'b10; end
      OP_BRANCH: begin branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; result_src = RES_PC4; imm_src = IMM_J; end
      default:   listed = 1'b0;
    endcase
  end

  // ALU decoder; subtraction via funct7[5] only applies to R-type
  always_comb begin
    alu_control = ALU_ADD;
    if (alu_op == 2'b01) begin
      alu_control = ALU_SUB;
    end else if (alu_op == 2'b10) begin
      case (funct3)
        3'b000:  alu_control = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: alu_control = ALU_ADD;
      endcase
    end
  end

  // Assemble the next ID/EX record; a flush turns it into an all-zero bubble
  always_comb begin
    id_ex_d = '0;
    if (!FlushE) begin
      id_ex_d.reg_write   = reg_write;
      id_ex_d.mem_write   = mem_write;
      id_ex_d.jump        = jump;
      id_ex_d.branch      = branch;
      id_ex_d.alu_src     = alu_src;
      id_ex_d.result_src  = result_src;
      id_ex_d.alu_control = alu_control;
      id_ex_d.rd1         = rd1;
      id_ex_d.rd2         = rd2;
      id_ex_d.imm_ext     = imm_extend(InstrD, imm_src);
      id_ex_d.pc          = PCD;
      id_ex_d.pc_plus4    = PCPlus4D;
      id_ex_d.rd          = InstrD[11:7];
      id_ex_d.rs1         = Rs1D;
      id_ex_d.rs2         = Rs2D;
    end
  end

  // ID/EX register; reset takes priority over flush
  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign RegWriteE   = id_ex_q.reg_write;
  assign MemWriteE   = id_ex_q.mem_write;
  assign JumpE       = id_ex_q.jump;
  assign BranchE     = id_ex_q.branch;
  assign ALUSrcE     = id_ex_q.alu_src;
  assign ResultSrcE  = id_ex_q.result_src;
  assign ALUControlE = id_ex_q.alu_control;
  assign RD1E        = id_ex_q.rd1;
  assign RD2E        = id_ex_q.rd2;
  assign ImmExtE     = id_ex_q.imm_ext;
  assign PCE         = id_ex_q.pc;
  assign PCPlus4E    = id_ex_q.pc_plus4;
  assign RdE         = id_ex_q.rd;
  assign Rs1E        = id_ex_q.rs1;
  assign Rs2E        = id_ex_q.rs2;

`ifdef DECODE_ILLEGAL_FLAG_EN
  logic illegal_d, illegal_q;

  // Flag unrecognised opcodes, but not the all-zero instruction
  always_comb begin
    illegal_d = !listed && (InstrD != 32'd0) && !FlushE;
  end

  // Illegal flag travels with the rest of the ID/EX record
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign IllegalE = illegal_q;
`else
  logic unused_listed;
  assign unused_listed = listed;
`endif

endmodule
